// File: rtl/mod_exp_host_if.sv
// Host register front end for the modular-exponentiation engine.
// Software loads operands word by word, kicks a run through CTRL, and reads
// back RESULT/STATUS. A run is LAUNCH (one-cycle engine pulse), WAIT (for the
// engine's done pulse, optionally watchdogged) and CAPTURE (latch result).
module mod_exp_host_if #(
    parameter int NBITS   = 2048,
    parameter int WBITS   = 32,
    parameter int TIMEOUT = 0,
    localparam int NW     = NBITS / WBITS,
    localparam int IW     = $clog2(NW),
    localparam int AW     = IW + 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [WBITS-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [WBITS-1:0]  rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              irq,
    output logic              me_enable_p,
    output logic [NBITS-1:0]  me_a,
    output logic [NBITS-1:0]  me_exp,
    output logic [NBITS-1:0]  me_m,
    output logic [NBITS-1:0]  me_r_red,
    output logic [11:0]       me_m_size,
    input  logic [NBITS-1:0]  me_y,
    input  logic              me_done_irq_p
);

    localparam logic [2:0] T_A      = 3'd0;
    localparam logic [2:0] T_EXP    = 3'd1;
    localparam logic [2:0] T_M      = 3'd2;
    localparam logic [2:0] T_RRED   = 3'd3;
    localparam logic [2:0] T_MSIZE  = 3'd4;
    localparam logic [2:0] T_CTRL   = 3'd5;
    localparam logic [2:0] T_RESULT = 3'd6;
    localparam logic [2:0] T_STATUS = 3'd7;

    // Last watchdog count value before the run is abandoned.
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, CAPTURE} state_e;

    state_e             state_q, state_d;
    logic [NBITS-1:0]   a_q, a_d, exp_q, exp_d, m_q, m_d, r_red_q, r_red_d;
    logic [NBITS-1:0]   result_q, result_d;
    logic [11:0]        m_size_q, m_size_d;
    logic               done_q, done_d, err_q, err_d;
    logic [31:0]        wd_cnt_q, wd_cnt_d;
    logic [WBITS-1:0]   rd_data_q, rd_data_d;
    logic               rd_valid_q, rd_valid_d;

    logic [2:0]         wr_tgt, rd_tgt;
    logic [IW-1:0]      wr_idx, rd_idx;
    logic               busy_w, ctrl_wr, op_wr;

    assign wr_tgt  = wr_addr[AW-1:IW];
    assign wr_idx  = wr_addr[IW-1:0];
    assign rd_tgt  = rd_addr[AW-1:IW];
    assign rd_idx  = rd_addr[IW-1:0];
    assign busy_w  = (state_q != IDLE);
    assign ctrl_wr = wr_en && (wr_tgt == T_CTRL);
    assign op_wr   = wr_en && (wr_tgt <= T_MSIZE);

    // Register writes, run sequencing, watchdog and read mux.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        exp_d       = exp_q;
        m_d         = m_q;
        r_red_d     = r_red_q;
        m_size_d    = m_size_q;
        result_d    = result_q;
        done_d      = done_q;
        err_d       = err_q;
        wd_cnt_d    = wd_cnt_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = rd_en;
        me_enable_p = 1'b0;
        irq         = 1'b0;

        // clr first so any error raised in the same cycle survives it
        if (ctrl_wr && wr_data[1]) begin
            done_d = 1'b0;
            err_d  = 1'b0;
        end
        if (ctrl_wr && wr_data[0] && busy_w)
            err_d = 1'b1;

        // operands are frozen for the whole run; late writes only flag err
        if (op_wr) begin
            if (busy_w) begin
                err_d = 1'b1;
            end else begin
                for (int k = 0; k < NW; k++) begin
                    if (wr_idx == IW'(k)) begin
                        case (wr_tgt)
                            T_A:     a_d[k*WBITS +: WBITS]     = wr_data;
                            T_EXP:   exp_d[k*WBITS +: WBITS]   = wr_data;
                            T_M:     m_d[k*WBITS +: WBITS]     = wr_data;
                            T_RRED:  r_red_d[k*WBITS +: WBITS] = wr_data;
                            default: ;
                        endcase
                    end
                end
                if (wr_tgt == T_MSIZE && wr_idx == '0)
                    m_size_d = wr_data[11:0];
            end
        end

        case (state_q)
            IDLE: begin
                if (ctrl_wr && wr_data[0]) begin
                    state_d = LAUNCH;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
            LAUNCH: begin
                me_enable_p = 1'b1;
                wd_cnt_d    = '0;
                state_d     = WAIT;
            end
            WAIT: begin
                if (me_done_irq_p) begin
                    state_d = CAPTURE;
                end else if (TIMEOUT != 0 && wd_cnt_q == TO_LAST) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                    irq     = 1'b1;
                end else begin
                    wd_cnt_d = wd_cnt_q + 32'd1;
                end
            end
            CAPTURE: begin
                // engine holds y after its done pulse, so sampling here is safe
                result_d = me_y;
                done_d   = 1'b1;
                irq      = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // reads see pre-update register values
        if (rd_en) begin
            rd_data_d = '0;
            if (rd_tgt == T_RESULT) begin
                for (int k = 0; k < NW; k++)
                    if (rd_idx == IW'(k))
                        rd_data_d = result_q[k*WBITS +: WBITS];
            end else if (rd_tgt == T_STATUS) begin
                rd_data_d[2:0] = {err_q, done_q, busy_w};
            end
        end
    end

    // State and register file update with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            a_q        <= '0;
            exp_q      <= '0;
            m_q        <= '0;
            r_red_q    <= '0;
            m_size_q   <= '0;
            result_q   <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            wd_cnt_q   <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            exp_q      <= exp_d;
            m_q        <= m_d;
            r_red_q    <= r_red_d;
            m_size_q   <= m_size_d;
            result_q   <= result_d;
            done_q     <= done_d;
            err_q      <= err_d;
            wd_cnt_q   <= wd_cnt_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign busy      = busy_w;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign me_a      = a_q;
    assign me_exp    = exp_q;
    assign me_m      = m_q;
    assign me_r_red  = r_red_q;
    assign me_m_size = m_size_q;

endmodule
